// File: rtl/cmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cmem_arbiter
//  Description : Two-port (instruction a / data b) round-robin arbiter in
//                front of a single downstream memory port. One transaction
//                is in flight at a time: IDLE grants, BUSY holds the latched
//                request until mem_resp, and DONE pulses the requester's
//                cmem_resp with the captured read data.
//  Revision    : 1.0  initial release
// ============================================================================
module cmem_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    // instruction port (a)
    input  logic        cmem_read_a,
    input  logic        cmem_write_a,
    input  logic [31:0] cmem_address_a,
    input  logic [31:0] cmem_wdata_a,
    input  logic [3:0]  cmem_byte_enable_a,
    output logic        cmem_resp_a,
    output logic [31:0] cmem_rdata_a,

    // data port (b)
    input  logic        cmem_read_b,
    input  logic        cmem_write_b,
    input  logic [31:0] cmem_address_b,
    input  logic [31:0] cmem_wdata_b,
    input  logic [3:0]  cmem_byte_enable_b,
    output logic        cmem_resp_b,
    output logic [31:0] cmem_rdata_b,

    // downstream memory
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Grant identifiers, also used as the encoding of last_grant.
    localparam logic c_grant_a = 1'b0;
    localparam logic c_grant_b = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_byte_enable_q, mem_byte_enable_d;
    logic        cmem_resp_a_q, cmem_resp_a_d;
    logic        cmem_resp_b_q, cmem_resp_b_d;
    logic [31:0] cmem_rdata_a_q, cmem_rdata_a_d;
    logic [31:0] cmem_rdata_b_q, cmem_rdata_b_d;

    logic        w_pend_a;
    logic        w_pend_b;
    logic        w_pick_b;

    // A port is pending on read or write; both high is treated as a write.
    assign w_pend_a = cmem_read_a | cmem_write_a;
    assign w_pend_b = cmem_read_b | cmem_write_b;

    // b wins when it is alone, or when both contend and a was served last.
    assign w_pick_b = w_pend_b & (~w_pend_a | (last_grant_q == c_grant_a));

    // Next-state, latch and response logic; every output is taken from a flop.
    always_comb begin
        state_d           = state_q;
        last_grant_d      = last_grant_q;
        grant_d           = grant_q;
        mem_read_d        = mem_read_q;
        mem_write_d       = mem_write_q;
        mem_address_d     = mem_address_q;
        mem_wdata_d       = mem_wdata_q;
        mem_byte_enable_d = mem_byte_enable_q;
        cmem_resp_a_d     = 1'b0;
        cmem_resp_b_d     = 1'b0;
        cmem_rdata_a_d    = cmem_rdata_a_q;
        cmem_rdata_b_d    = cmem_rdata_b_q;

        case (state_q)
            ST_IDLE: begin
                if (w_pend_a | w_pend_b) begin
                    grant_d      = w_pick_b;
                    last_grant_d = w_pick_b;
                    state_d      = ST_BUSY;
                    if (w_pick_b) begin
                        mem_write_d       = cmem_write_b;
                        mem_read_d        = cmem_read_b & ~cmem_write_b;
                        mem_address_d     = cmem_address_b;
                        mem_wdata_d       = cmem_wdata_b;
                        mem_byte_enable_d = cmem_byte_enable_b;
                    end else begin
                        mem_write_d       = cmem_write_a;
                        mem_read_d        = cmem_read_a & ~cmem_write_a;
                        mem_address_d     = cmem_address_a;
                        mem_wdata_d       = cmem_wdata_a;
                        mem_byte_enable_d = cmem_byte_enable_a;
                    end
                end
            end

            ST_BUSY: begin
                // The latched request is completed even if the requester has
                // since dropped its request lines.
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = ST_DONE;
                    if (grant_q == c_grant_b) begin
                        cmem_resp_b_d  = 1'b1;
                        cmem_rdata_b_d = mem_rdata;
                    end else begin
                        cmem_resp_a_d  = 1'b1;
                        cmem_rdata_a_d = mem_rdata;
                    end
                end
            end

            // The response pulse is visible during this state; no
            // arbitration happens here so the next grant is made in IDLE.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            last_grant_q      <= c_grant_a;
            grant_q           <= c_grant_a;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            mem_address_q     <= 32'd0;
            mem_wdata_q       <= 32'd0;
            mem_byte_enable_q <= 4'd0;
            cmem_resp_a_q     <= 1'b0;
            cmem_resp_b_q     <= 1'b0;
            cmem_rdata_a_q    <= 32'd0;
            cmem_rdata_b_q    <= 32'd0;
        end else begin
            state_q           <= state_d;
            last_grant_q      <= last_grant_d;
            grant_q           <= grant_d;
            mem_read_q        <= mem_read_d;
            mem_write_q       <= mem_write_d;
            mem_address_q     <= mem_address_d;
            mem_wdata_q       <= mem_wdata_d;
            mem_byte_enable_q <= mem_byte_enable_d;
            cmem_resp_a_q     <= cmem_resp_a_d;
            cmem_resp_b_q     <= cmem_resp_b_d;
            cmem_rdata_a_q    <= cmem_rdata_a_d;
            cmem_rdata_b_q    <= cmem_rdata_b_d;
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_byte_enable_q;
    assign cmem_resp_a     = cmem_resp_a_q;
    assign cmem_resp_b     = cmem_resp_b_q;
    assign cmem_rdata_a    = cmem_rdata_a_q;
    assign cmem_rdata_b    = cmem_rdata_b_q;

endmodule
`default_nettype wire

// File: tb/tb_cmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmem_arbiter
//  Description : Self-checking bench for cmem_arbiter: reset values, table of
//                single transactions, round-robin contention, dropped request,
//                reset mid-transaction and a randomized run against a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cmem_read_a, cmem_write_a;
    logic [31:0] cmem_address_a, cmem_wdata_a;
    logic [3:0]  cmem_byte_enable_a;
    logic        cmem_resp_a;
    logic [31:0] cmem_rdata_a;
    logic        cmem_read_b, cmem_write_b;
    logic [31:0] cmem_address_b, cmem_wdata_b;
    logic [3:0]  cmem_byte_enable_b;
    logic        cmem_resp_b;
    logic [31:0] cmem_rdata_b;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    cmem_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmem_read_a        (cmem_read_a),
        .cmem_write_a       (cmem_write_a),
        .cmem_address_a     (cmem_address_a),
        .cmem_wdata_a       (cmem_wdata_a),
        .cmem_byte_enable_a (cmem_byte_enable_a),
        .cmem_resp_a        (cmem_resp_a),
        .cmem_rdata_a       (cmem_rdata_a),
        .cmem_read_b        (cmem_read_b),
        .cmem_write_b       (cmem_write_b),
        .cmem_address_b     (cmem_address_b),
        .cmem_wdata_b       (cmem_wdata_b),
        .cmem_byte_enable_b (cmem_byte_enable_b),
        .cmem_resp_b        (cmem_resp_b),
        .cmem_rdata_b       (cmem_rdata_b),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_address        (mem_address),
        .mem_wdata          (mem_wdata),
        .mem_byte_enable    (mem_byte_enable),
        .mem_resp           (mem_resp),
        .mem_rdata          (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic p, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        if (p) begin
            cmem_read_b = rd; cmem_write_b = wr; cmem_address_b = addr;
            cmem_wdata_b = wd; cmem_byte_enable_b = be;
        end else begin
            cmem_read_a = rd; cmem_write_a = wr; cmem_address_a = addr;
            cmem_wdata_a = wd; cmem_byte_enable_a = be;
        end
    endtask

    task automatic clear_req(input logic p);
        if (p) begin cmem_read_b = 1'b0; cmem_write_b = 1'b0; end
        else   begin cmem_read_a = 1'b0; cmem_write_a = 1'b0; end
    endtask

    // Advance until a downstream request is visible, with a cycle budget.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_read | mem_write) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_req: got no downstream request in 10 cycles, expected one");
        end
    endtask

    // ---------------- table of single transactions ----------------
    typedef struct {
        logic        port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;     // cycles of mem_read/write before mem_resp cycle
        logic [31:0] rdata;
        logic        exp_read;
        logic        exp_write;
    } vec_t;

    vec_t vecs [4];

    task automatic run_vec(input vec_t v);
        drive_req(v.port, v.rd, v.wr, v.addr, v.wdata, v.be);
        @(negedge clk);
        for (int c = 0; c <= v.delay; c++) begin
            chk1 ("vec mem_read",  mem_read,  v.exp_read);
            chk1 ("vec mem_write", mem_write, v.exp_write);
            chk32("vec mem_address", mem_address, v.addr);
            if (v.exp_write) chk32("vec mem_wdata", mem_wdata, v.wdata);
            chk32("vec mem_byte_enable", {28'd0, mem_byte_enable}, {28'd0, v.be});
            chk1 ("vec early resp_a", cmem_resp_a, 1'b0);
            chk1 ("vec early resp_b", cmem_resp_b, 1'b0);
            if (c == v.delay) begin
                mem_resp  = 1'b1;
                mem_rdata = v.rdata;
            end
            @(negedge clk);
        end
        mem_resp = 1'b0;
        chk1("vec resp_a", cmem_resp_a, v.port == 1'b0);
        chk1("vec resp_b", cmem_resp_b, v.port == 1'b1);
        if (v.exp_read)
            chk32("vec rdata", v.port ? cmem_rdata_b : cmem_rdata_a, v.rdata);
        chk1("vec mem_read after resp",  mem_read,  1'b0);
        chk1("vec mem_write after resp", mem_write, 1'b0);
        clear_req(v.port);
        @(negedge clk);
        chk1("vec resp_a one cycle", cmem_resp_a, 1'b0);
        chk1("vec resp_b one cycle", cmem_resp_b, 1'b0);
    endtask

    // Both ports request reads; grants must alternate starting with b.
    // With keep set the served port immediately re-requests a new address.
    task automatic contend(input int num, input bit keep);
        logic [31:0] adr_a, adr_b;
        logic        exp_b;
        bit          ok;
        adr_a = 32'h0000_0A00;
        adr_b = 32'h0000_0B00;
        drive_req(1'b0, 1'b1, 1'b0, adr_a, 32'd0, 4'hF);
        drive_req(1'b1, 1'b1, 1'b0, adr_b, 32'd0, 4'hF);
        for (int n = 0; n < num; n++) begin
            exp_b = ((n % 2) == 0);
            wait_req(ok);
            if (ok) begin
                chk32("rr grant address", mem_address, exp_b ? adr_b : adr_a);
                mem_resp  = 1'b1;
                mem_rdata = 32'hC0DE_0000 | 32'(n);
                @(negedge clk);
                mem_resp = 1'b0;
                chk1 ("rr resp_a", cmem_resp_a, !exp_b);
                chk1 ("rr resp_b", cmem_resp_b, exp_b);
                chk32("rr rdata", exp_b ? cmem_rdata_b : cmem_rdata_a, 32'hC0DE_0000 | 32'(n));
                if (keep) begin
                    if (exp_b) begin adr_b = adr_b + 32'd4; cmem_address_b = adr_b; end
                    else       begin adr_a = adr_a + 32'd4; cmem_address_a = adr_a; end
                end else begin
                    clear_req(exp_b);
                end
            end
        end
        clear_req(1'b0);
        clear_req(1'b1);
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        m_txn;
    bit          m_active;      // a granted transaction is out downstream
    bit          m_gap;         // response cycle: no new grant this cycle
    logic        m_last;        // port served most recently (0 = a)
    logic        e_resp_a, e_resp_b;
    logic        e_rd_a, e_rd_b;
    logic [31:0] e_rdata_a, e_rdata_b;

    task automatic model_reset();
        m_active = 1'b0; m_gap = 1'b0; m_last = 1'b0;
        e_resp_a = 1'b0; e_resp_b = 1'b0; e_rd_a = 1'b0; e_rd_b = 1'b0;
        e_rdata_a = 32'd0; e_rdata_b = 32'd0;
        m_txn = '{1'b0, 1'b0, 32'd0, 32'd0, 4'd0};
    endtask

    // Predict the effect of the coming rising edge from the driven inputs.
    task automatic model_step();
        logic pa, pb, port;
        pa = cmem_read_a | cmem_write_a;
        pb = cmem_read_b | cmem_write_b;
        e_resp_a = 1'b0;
        e_resp_b = 1'b0;
        if (m_active) begin
            if (mem_resp) begin
                m_active = 1'b0;
                m_gap    = 1'b1;
                if (m_txn.port) begin e_resp_b = 1'b1; e_rdata_b = mem_rdata; e_rd_b = !m_txn.wr; end
                else            begin e_resp_a = 1'b1; e_rdata_a = mem_rdata; e_rd_a = !m_txn.wr; end
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (pa || pb) begin
            if (pa && pb) port = ~m_last;
            else          port = pb;
            if (port) m_txn = '{1'b1, cmem_write_b, cmem_address_b, cmem_wdata_b, cmem_byte_enable_b};
            else      m_txn = '{1'b0, cmem_write_a, cmem_address_a, cmem_wdata_a, cmem_byte_enable_a};
            m_active = 1'b1;
            m_last   = port;
        end
    endtask

    task automatic model_check();
        chk1("rnd mem_read",  mem_read,  m_active && !m_txn.wr);
        chk1("rnd mem_write", mem_write, m_active && m_txn.wr);
        if (m_active) begin
            chk32("rnd mem_address", mem_address, m_txn.addr);
            if (m_txn.wr) chk32("rnd mem_wdata", mem_wdata, m_txn.wdata);
            chk32("rnd mem_byte_enable", {28'd0, mem_byte_enable}, {28'd0, m_txn.be});
        end
        chk1("rnd resp_a", cmem_resp_a, e_resp_a);
        chk1("rnd resp_b", cmem_resp_b, e_resp_b);
        if (e_resp_a && e_rd_a) chk32("rnd rdata_a", cmem_rdata_a, e_rdata_a);
        if (e_resp_b && e_rd_b) chk32("rnd rdata_b", cmem_rdata_b, e_rdata_b);
        chk1("rnd resp exclusive", cmem_resp_a & cmem_resp_b, 1'b0);
    endtask

    task automatic rand_req(input logic p);
        int op;
        op = $urandom_range(0, 2);
        drive_req(p, op != 1, op != 0, $urandom, $urandom, 4'($urandom_range(0, 15)));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ra_on, rb_on;
        int mem_wait;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0000_0000, 4'hF,    2, 32'h00A0_0093, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 1, 32'h5555_5555, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'h1234_5678, 4'b1100, 0, 32'h7777_0000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0508, 32'h0000_0000, 4'hF,    3, 32'hCAFE_F00D, 1'b1, 1'b0};

        rst_n = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_resp  = 1'b0;
        mem_rdata = 32'd0;
        repeat (2) @(negedge clk);

        // reset values
        chk1 ("reset mem_read",  mem_read,  1'b0);
        chk1 ("reset mem_write", mem_write, 1'b0);
        chk32("reset mem_address", mem_address, 32'd0);
        chk32("reset mem_wdata", mem_wdata, 32'd0);
        chk32("reset mem_byte_enable", {28'd0, mem_byte_enable}, 32'd0);
        chk1 ("reset resp_a", cmem_resp_a, 1'b0);
        chk1 ("reset resp_b", cmem_resp_b, 1'b0);
        chk32("reset rdata_a", cmem_rdata_a, 32'd0);
        chk32("reset rdata_b", cmem_rdata_b, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // simultaneous reads right after reset: b first, then a
        contend(2, 1'b0);
        // continuous contention over 6 transactions: B A B A B A
        contend(6, 1'b1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // requester drops its read while the downstream read is in flight
        drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 4'hF);
        @(negedge clk);
        chk1 ("drop mem_read", mem_read, 1'b1);
        clear_req(1'b0);
        cmem_address_a = 32'hFFFF_FFFF;
        @(negedge clk);
        chk1 ("drop mem_read held", mem_read, 1'b1);
        chk32("drop mem_address held", mem_address, 32'h0000_0300);
        mem_resp  = 1'b1;
        mem_rdata = 32'h3131_3131;
        @(negedge clk);
        mem_resp = 1'b0;
        chk1 ("drop resp_a", cmem_resp_a, 1'b1);
        chk1 ("drop resp_b", cmem_resp_b, 1'b0);
        chk32("drop rdata_a", cmem_rdata_a, 32'h3131_3131);
        @(negedge clk);
        chk1 ("drop resp_a one cycle", cmem_resp_a, 1'b0);
        chk1 ("drop mem_read idle", mem_read, 1'b0);

        // reset asserted while busy: outputs clear at once, no response
        drive_req(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'd0, 4'hF);
        @(negedge clk);
        chk1("rstmid mem_read before", mem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1 ("rstmid mem_read", mem_read, 1'b0);
        chk32("rstmid mem_address", mem_address, 32'd0);
        chk1 ("rstmid resp_a", cmem_resp_a, 1'b0);
        chk32("rstmid rdata_a", cmem_rdata_a, 32'd0);
        clear_req(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rstmid resp_a after", cmem_resp_a, 1'b0);
        chk1("rstmid mem_read after", mem_read, 1'b0);
        run_vec(vecs[3]);

        // randomized run against the reference model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        ra_on = 1'b0;
        rb_on = 1'b0;
        mem_wait = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (e_resp_a) begin ra_on = 1'b0; clear_req(1'b0); end
            if (e_resp_b) begin rb_on = 1'b0; clear_req(1'b1); end
            if (!ra_on && $urandom_range(0, 2) == 0) begin rand_req(1'b0); ra_on = 1'b1; end
            if (!rb_on && $urandom_range(0, 2) == 0) begin rand_req(1'b1); rb_on = 1'b1; end

            mem_resp = 1'b0;
            if (mem_read | mem_write) begin
                if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
                if (mem_wait == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = $urandom;
                    mem_wait  = -1;
                end else begin
                    mem_wait--;
                end
            end else begin
                // stray responses while nothing is outstanding
                mem_wait  = -1;
                mem_resp  = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end

            model_step();
            @(negedge clk);
            model_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
